// File: rtl/activation_pkg.sv
// Shared definitions for the piecewise-linear sigmoid stage.
// Constants are kept in 1/32 units and scaled up to the datapath precision.
package activation_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    // Internal precision carries this many bits beyond FRACTION_WIDTH.
    localparam int EXTRA_FRAC = 5;

    // Breakpoints 1, 2.375, 5 in units of 2^-EXTRA_FRAC.
    localparam int BP1_Q = 32;
    localparam int BP2_Q = 76;
    localparam int BP3_Q = 160;

    // Slopes 1/4, 1/8, 1/32 as right-shift amounts.
    localparam int SH0 = 2;
    localparam int SH1 = 3;
    localparam int SH2 = 5;

    // Offsets 0.5, 0.625, 0.84375 in units of 2^-EXTRA_FRAC.
    localparam int OFF0_Q = 16;
    localparam int OFF1_Q = 20;
    localparam int OFF2_Q = 27;

    function automatic int to_int(input int q, input int fw);
        return q << fw;
    endfunction

endpackage

// File: rtl/sigmoid_pwl_cell.sv
// Combinational sigmoid approximation for one signed fixed-point cell,
// producing the truncated activation and its y*(1-y) derivative.
module sigmoid_pwl_cell
    import activation_pkg::*;
#(
    parameter int INPUT_CELL_WIDTH  = 8,
    parameter int OUTPUT_CELL_WIDTH = 8,
    parameter int FRACTION_WIDTH    = 4
) (
    input  logic [INPUT_CELL_WIDTH-1:0]  x,
    output logic [OUTPUT_CELL_WIDTH-1:0] act,
    output logic [OUTPUT_CELL_WIDTH-1:0] der
);

    localparam int XW = (INPUT_CELL_WIDTH > FRACTION_WIDTH + 3) ?
                        INPUT_CELL_WIDTH : FRACTION_WIDTH + 3;
    localparam int IW = XW + EXTRA_FRAC + 1;
    localparam int FW = FRACTION_WIDTH;

    localparam logic [IW-1:0] BP1  = IW'(to_int(BP1_Q, FW));
    localparam logic [IW-1:0] BP2  = IW'(to_int(BP2_Q, FW));
    localparam logic [IW-1:0] BP3  = IW'(to_int(BP3_Q, FW));
    localparam logic [IW-1:0] OFF0 = IW'(to_int(OFF0_Q, FW));
    localparam logic [IW-1:0] OFF1 = IW'(to_int(OFF1_Q, FW));
    localparam logic [IW-1:0] OFF2 = IW'(to_int(OFF2_Q, FW));
    localparam logic [IW-1:0] ONE_I = IW'(1) << (FW + EXTRA_FRAC);
    localparam logic [FW:0]   ONE_T = {1'b1, {FW{1'b0}}};

    logic          neg;
    logic [IW-1:0] xs;
    logic [IW-1:0] mag;
    logic [IW-1:0] a_i;
    logic [IW-1:0] y_pos;
    logic [IW-1:0] y;
    logic [FW:0]   yt;
    logic [2*FW+1:0] prod;

    always_comb begin
        neg  = x[INPUT_CELL_WIDTH-1];
        xs   = IW'($signed(x));
        // Extra headroom bit keeps |most negative input| representable.
        mag  = neg ? (~xs + IW'(1)) : xs;
        a_i  = mag << EXTRA_FRAC;
        if (a_i >= BP3) begin
            y_pos = ONE_I;
        end else if (a_i >= BP2) begin
            y_pos = (a_i >> SH2) + OFF2;
        end else if (a_i >= BP1) begin
            y_pos = (a_i >> SH1) + OFF1;
        end else begin
            y_pos = (a_i >> SH0) + OFF0;
        end
        y    = neg ? (ONE_I - y_pos) : y_pos;
        yt   = (FW+1)'(y >> EXTRA_FRAC);
        prod = yt * (ONE_T - yt);
        act  = OUTPUT_CELL_WIDTH'(yt);
        der  = OUTPUT_CELL_WIDTH'(prod >> FW);
    end

endmodule

// File: rtl/activation_sigmoid.sv
// Sigmoid/derivative stage after the MVM: latches a vector, evaluates
// TILING cells per cycle and holds both result vectors for the consumer.
module activation_sigmoid
    import activation_pkg::*;
#(
    parameter int NEURON_NUM        = 4,
    parameter int INPUT_CELL_WIDTH  = 8,
    parameter int OUTPUT_CELL_WIDTH = 8,
    parameter int FRACTION_WIDTH    = 4,
    parameter int TILING            = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NEURON_NUM*INPUT_CELL_WIDTH-1:0]  in_vector,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [NEURON_NUM*OUTPUT_CELL_WIDTH-1:0] activation,
    output logic [NEURON_NUM*OUTPUT_CELL_WIDTH-1:0] derivative,
    output logic                                   out_valid,
    input  logic                                   out_ready
);

    localparam int IW   = INPUT_CELL_WIDTH;
    localparam int OW   = OUTPUT_CELL_WIDTH;
    localparam int IDXW = $clog2(NEURON_NUM + TILING) + 1;

    state_e                   state_q, state_d;
    logic [IDXW-1:0]          idx_q, idx_d, idx_next;
    logic [NEURON_NUM*IW-1:0] in_buf_q, in_buf_d;
    logic [NEURON_NUM*OW-1:0] act_q, act_d;
    logic [NEURON_NUM*OW-1:0] der_q, der_d;

    logic [IDXW-1:0] lane_idx [TILING];
    logic [IW-1:0]   lane_x   [TILING];
    logic [OW-1:0]   lane_act [TILING];
    logic [OW-1:0]   lane_der [TILING];

    // Lanes past the last neuron match no cell, so they read 0 and write nothing.
    always_comb begin
        for (int l = 0; l < TILING; l++) begin
            lane_idx[l] = idx_q + IDXW'(l);
            lane_x[l]   = '0;
            for (int n = 0; n < NEURON_NUM; n++) begin
                if (lane_idx[l] == IDXW'(n)) begin
                    lane_x[l] = in_buf_q[n*IW +: IW];
                end
            end
        end
    end

    for (genvar g = 0; g < TILING; g++) begin : g_lane
        sigmoid_pwl_cell #(
            .INPUT_CELL_WIDTH (INPUT_CELL_WIDTH),
            .OUTPUT_CELL_WIDTH(OUTPUT_CELL_WIDTH),
            .FRACTION_WIDTH   (FRACTION_WIDTH)
        ) u_cell (
            .x  (lane_x[g]),
            .act(lane_act[g]),
            .der(lane_der[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        in_buf_d = in_buf_q;
        act_d    = act_q;
        der_d    = der_q;
        idx_next = idx_q + IDXW'(TILING);
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_buf_d = in_vector;
                    idx_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                for (int n = 0; n < NEURON_NUM; n++) begin
                    for (int l = 0; l < TILING; l++) begin
                        if (lane_idx[l] == IDXW'(n)) begin
                            act_d[n*OW +: OW] = lane_act[l];
                            der_d[n*OW +: OW] = lane_der[l];
                        end
                    end
                end
                idx_d = idx_next;
                if (idx_next >= IDXW'(NEURON_NUM)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            in_buf_q <= '0;
            act_q    <= '0;
            der_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            in_buf_q <= in_buf_d;
            act_q    <= act_d;
            der_q    <= der_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign activation = act_q;
    assign derivative = der_q;

endmodule

// File: tb/tb_activation_sigmoid.sv
// Scoreboard bench for activation_sigmoid: default build plus a
// five-neuron build exercising an idle lane in the final CALC cycle.
module tb_activation_sigmoid;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int OW = 8;
    localparam int C  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N*W-1:0]  in_vector;
    logic            in_valid;
    logic            in_ready;
    logic [N*OW-1:0] activation;
    logic [N*OW-1:0] derivative;
    logic            out_valid;
    logic            out_ready;

    logic [5*W-1:0]  in_vector2;
    logic            in_valid2;
    logic            in_ready2;
    logic [5*OW-1:0] act2;
    logic [5*OW-1:0] der2;
    logic            out_valid2;
    logic            out_ready2;

    activation_sigmoid dut (
        .clk       (clk),
        .rst       (rst),
        .in_vector (in_vector),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .activation(activation),
        .derivative(derivative),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    activation_sigmoid #(
        .NEURON_NUM(5),
        .TILING    (2)
    ) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_vector (in_vector2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .activation(act2),
        .derivative(der2),
        .out_valid (out_valid2),
        .out_ready (out_ready2)
    );

    typedef struct packed {
        logic [39:0] a;
        logic [39:0] d;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [39:0] p5(input int c0, c1, c2, c3, c4);
        return {8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    exp_t e1;
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: act %h with empty queue",
                         activation);
            end else begin
                e1 = q1.pop_front();
                chk("activation", 64'(activation), 64'(e1.a));
                chk("derivative", 64'(derivative), 64'(e1.d));
            end
        end
    end

    exp_t e2;
    always @(negedge clk) begin
        if (rst && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out5: act %h with empty queue",
                         act2);
            end else begin
                e2 = q2.pop_front();
                chk("activation5", 64'(act2), 64'(e2.a));
                chk("derivative5", 64'(der2), 64'(e2.d));
            end
        end
    end

    task automatic send(input logic [39:0] v, input logic [39:0] ea,
                        input logic [39:0] ed, input bit hold,
                        input bit chk_lat, output int acc);
        int t;
        @(negedge clk);
        in_vector = v[N*W-1:0];
        in_valid  = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready %b after %0d cycles",
                     in_ready, t);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        acc = cyc;
        q1.push_back('{a: ea, d: ed});
        #1;
        if (!hold) in_valid = 1'b0;
        if (chk_lat) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!out_valid && t < 20);
            chk("latency", 64'(t), 64'(C + 1));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q1.size() != 0 || !in_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(q1.size()), 64'(0));
    endtask

    int acc0, acc1, acc2;
    logic [N*OW-1:0] hold_a, hold_d;

    initial begin
        in_valid   = 1'b0;
        in_vector  = '0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_vector2 = '0;
        out_ready2 = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_act", 64'(activation), 64'(0));
        chk("rst_der", 64'(derivative), 64'(0));
        rst = 1'b1;

        send(p5(0, 16, -16, 127, 0), p5(8, 12, 4, 16, 0),
             p5(4, 3, 3, 0, 0), 1'b0, 1'b1, acc0);
        drain();
        send(p5(40, -40, -128, 37, 0), p5(14, 1, 0, 14, 0),
             p5(1, 0, 0, 1, 0), 1'b0, 1'b1, acc0);
        drain();
        send(p5(-1, 1, 80, -80, 0), p5(7, 8, 16, 0, 0),
             p5(3, 4, 0, 0, 0), 1'b0, 1'b0, acc0);
        drain();

        // back-pressure with a stray input pulse while results are held
        out_ready = 1'b0;
        send(p5(38, -38, 79, 15, 0), p5(14, 1, 15, 11, 0),
             p5(1, 0, 0, 3, 0), 1'b0, 1'b1, acc0);
        hold_a = activation;
        hold_d = derivative;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                in_vector = p5(0, 16, -16, 127, 0)[N*W-1:0];
                in_valid  = 1'b1;
            end
            if (i == 4) in_valid = 1'b0;
            chk("bp_act_stable", 64'(activation), 64'(hold_a));
            chk("bp_der_stable", 64'(derivative), 64'(hold_d));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'(1));
        chk("bp_release_out_valid", 64'(out_valid), 64'(0));
        chk("bp_queue_empty", 64'(q1.size()), 64'(0));

        // asynchronous reset in the middle of CALC
        send(p5(0, 16, -16, 127, 0), p5(8, 12, 4, 16, 0),
             p5(4, 3, 3, 0, 0), 1'b0, 1'b0, acc0);
        @(negedge clk);
        rst = 1'b0;
        q1.delete();
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_act", 64'(activation), 64'(0));
        chk("abort_der", 64'(derivative), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        send(p5(40, -40, -128, 37, 0), p5(14, 1, 0, 14, 0),
             p5(1, 0, 0, 1, 0), 1'b0, 1'b1, acc0);
        drain();

        // back-to-back with in_valid held high
        out_ready = 1'b1;
        send(p5(-1, 1, 80, -80, 0), p5(7, 8, 16, 0, 0),
             p5(3, 4, 0, 0, 0), 1'b1, 1'b0, acc0);
        send(p5(38, -38, 79, 15, 0), p5(14, 1, 15, 11, 0),
             p5(1, 0, 0, 3, 0), 1'b1, 1'b0, acc1);
        send(p5(0, 16, -16, 127, 0), p5(8, 12, 4, 16, 0),
             p5(4, 3, 3, 0, 0), 1'b1, 1'b0, acc2);
        in_valid = 1'b0;
        chk("b2b_period_a", 64'(acc1 - acc0), 64'(C + 2));
        chk("b2b_period_b", 64'(acc2 - acc1), 64'(C + 2));
        drain();

        // five neurons, two lanes: three CALC cycles, idle lane at the end
        @(negedge clk);
        in_vector2 = p5(0, 16, -16, 127, 80);
        in_valid2  = 1'b1;
        chk("odd_in_ready", 64'(in_ready2), 64'(1));
        @(posedge clk);
        q2.push_back('{a: p5(8, 12, 4, 16, 16), d: p5(4, 3, 3, 0, 0)});
        #1 in_valid2 = 1'b0;
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!out_valid2 && t < 20);
            chk("odd_latency", 64'(t), 64'(4));
            t = 0;
            while ((q2.size() != 0 || !in_ready2) && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("odd_drain", 64'(q2.size()), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
